// File: rtl/ldpc_din_framer.sv
// ldpc_din_framer
// ---------------
// Framing stage between the Gaussian LLR generator and the LDPC decoder.
// It cuts the continuous LLR stream into codeword-sized blocks, marks the
// last beat of each block with tlast and sends one CTRL word ahead of every
// block. An optional block budget ends a run, and the blocks delivered in
// the current run are counted.
//
// Ports
//   clk, reset            : datapath clock, synchronous active-high reset
//   en                    : run enable (level)
//   block_beats           : beats per codeword, sampled at each block start
//   max_blocks            : block budget (0 = unlimited), sampled at run start
//   ctrl_word             : decoder control word, sampled at each block start
//   s_axis_*              : LLR beats from the generator
//   m_axis_din_*          : framed LLR beats to the decoder (with tlast)
//   m_axis_ctrl_*         : latched control word to the decoder
//   blocks_sent           : blocks fully delivered in the current run
//   busy / done           : not IDLE / in DONE
module ldpc_din_framer #(
   parameter int DATA_W = 128,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [LEN_W-1:0]  block_beats,
   input  logic [31:0]       max_blocks,
   input  logic [31:0]       ctrl_word,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_din_tdata,
   output logic              m_axis_din_tvalid,
   input  logic              m_axis_din_tready,
   output logic              m_axis_din_tlast,
   output logic [31:0]       m_axis_ctrl_tdata,
   output logic              m_axis_ctrl_tvalid,
   input  logic              m_axis_ctrl_tready,
   output logic [63:0]       blocks_sent,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CTRL = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_in_cnt;
   logic [31:0]       r_max;
   logic [31:0]       r_ctrl_data;
   logic [63:0]       r_blocks;
   logic [DATA_W-1:0] r_dout;
   logic              r_dvalid;
   logic              r_dlast;

   logic              w_s_ready;
   logic              w_in_fire;
   logic              w_blk_end;
   logic [63:0]       w_blocks_inc;
   logic              w_budget_hit;
   logic              w_next_ok;

   // Accept only while the current block still has beats to take and the
   // single output register is free or being drained this cycle.
   assign w_s_ready    = (r_state == S_DATA) && (r_in_cnt < r_len) &&
                         (!r_dvalid || m_axis_din_tready);
   assign w_in_fire    = s_axis_tvalid && w_s_ready;
   assign w_blk_end    = r_dvalid && m_axis_din_tready && r_dlast;
   assign w_blocks_inc = r_blocks + 64'd1;
   // Budget is 32-bit; upper count bits must be zero for a match.
   assign w_budget_hit = (r_max != 32'd0) && (w_blocks_inc == {32'd0, r_max});
   assign w_next_ok    = en && (block_beats != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_in_cnt    <= '0;
         r_max       <= '0;
         r_ctrl_data <= '0;
         r_blocks    <= '0;
         r_dout      <= '0;
         r_dvalid    <= 1'b0;
         r_dlast     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_next_ok) begin
                  r_state     <= S_CTRL;
                  r_len       <= block_beats;
                  r_ctrl_data <= ctrl_word;
                  r_max       <= max_blocks;
                  r_blocks    <= '0;
               end
            end
            S_CTRL: begin
               if (m_axis_ctrl_tready) begin
                  r_state  <= S_DATA;
                  r_in_cnt <= '0;
               end
            end
            S_DATA: begin
               // A block ends only when its tlast beat leaves; en is not
               // consulted before that, so blocks are never truncated.
               if (w_blk_end) begin
                  r_blocks <= w_blocks_inc;
                  if (w_budget_hit) begin
                     r_state <= S_DONE;
                  end else if (w_next_ok) begin
                     r_state     <= S_CTRL;
                     r_len       <= block_beats;
                     r_ctrl_data <= ctrl_word;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               if (!en) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Single output register stage; in_fire only happens in DATA so it
         // never collides with the counter clear in CTRL.
         if (w_in_fire) begin
            r_dout   <= s_axis_tdata;
            r_dlast  <= (r_in_cnt == (r_len - 1'b1));
            r_dvalid <= 1'b1;
            r_in_cnt <= r_in_cnt + 1'b1;
         end else if (m_axis_din_tready) begin
            r_dvalid <= 1'b0;
            r_dlast  <= 1'b0;
         end
      end
   end

   assign s_axis_tready      = w_s_ready;
   assign m_axis_din_tdata   = r_dout;
   assign m_axis_din_tvalid  = r_dvalid;
   assign m_axis_din_tlast   = r_dlast;
   assign m_axis_ctrl_tdata  = r_ctrl_data;
   assign m_axis_ctrl_tvalid = (r_state == S_CTRL);
   assign blocks_sent        = r_blocks;
   assign busy               = (r_state != S_IDLE);
   assign done               = (r_state == S_DONE);

endmodule

// File: tb/tb_ldpc_din_framer.sv
// Testbench for ldpc_din_framer: randomized source/sink with a scoreboard.
// Accepted source beats are queued as expected DIN beats; expected CTRL words
// are queued when a run is started. A negedge monitor pops and compares.
module tb_ldpc_din_framer;
   localparam int DATA_W = 128;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en = 1'b0;
   logic [LEN_W-1:0]  block_beats = '0;
   logic [31:0]       max_blocks = '0;
   logic [31:0]       ctrl_word = '0;
   logic [DATA_W-1:0] s_axis_tdata = '0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_din_tdata;
   logic              m_axis_din_tvalid;
   logic              m_axis_din_tready = 1'b1;
   logic              m_axis_din_tlast;
   logic [31:0]       m_axis_ctrl_tdata;
   logic              m_axis_ctrl_tvalid;
   logic              m_axis_ctrl_tready = 1'b1;
   logic [63:0]       blocks_sent;
   logic              busy;
   logic              done;

   ldpc_din_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .en(en), .block_beats(block_beats),
      .max_blocks(max_blocks), .ctrl_word(ctrl_word),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_din_tdata(m_axis_din_tdata), .m_axis_din_tvalid(m_axis_din_tvalid),
      .m_axis_din_tready(m_axis_din_tready), .m_axis_din_tlast(m_axis_din_tlast),
      .m_axis_ctrl_tdata(m_axis_ctrl_tdata), .m_axis_ctrl_tvalid(m_axis_ctrl_tvalid),
      .m_axis_ctrl_tready(m_axis_ctrl_tready),
      .blocks_sent(blocks_sent), .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_W-1:0] exp_din_q[$];
   logic [31:0]       exp_ctrl_q[$];
   int cur_len = 1;
   int out_idx = 0;
   int din_beats = 0;
   int n_last = 0;
   int n_ctrl = 0;
   int hs_cyc = 0;
   int first_din_cyc = 0;
   bit gen_acc = 0;
   bit rand_src = 0;
   bit rand_rdy = 0;
   bit d_stall = 0;
   bit c_stall = 0;
   logic [DATA_W-1:0] d_prev;
   logic              d_prev_last;
   logic [31:0]       c_prev;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Source generator and DIN sink driver (inputs change 1 ns after posedge)
   initial forever begin
      @(posedge clk);
      #1;
      if (gen_acc || !s_axis_tvalid) begin
         s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
         s_axis_tvalid = rand_src ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      m_axis_din_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (reset) begin
         gen_acc = 0;
         d_stall = 0;
         c_stall = 0;
      end else begin
         if (d_stall) begin
            chk("din_stall_valid", m_axis_din_tvalid, 1);
            chk("din_stall_data", m_axis_din_tdata, d_prev);
            chk("din_stall_last", m_axis_din_tlast, d_prev_last);
         end
         if (c_stall) begin
            chk("ctrl_stall_valid", m_axis_ctrl_tvalid, 1);
            chk("ctrl_stall_data", m_axis_ctrl_tdata, c_prev);
         end
         gen_acc = s_axis_tvalid && s_axis_tready;
         if (gen_acc) exp_din_q.push_back(s_axis_tdata);
         if (m_axis_din_tvalid && m_axis_din_tready) begin
            if (exp_din_q.size() == 0) begin
               chk("din_unexpected_beat", m_axis_din_tvalid, 0);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_din_q.pop_front();
               chk("din_data", m_axis_din_tdata, e);
               chk("din_tlast", m_axis_din_tlast, ((out_idx % cur_len) == cur_len - 1));
            end
            if (din_beats == 0) first_din_cyc = cyc;
            out_idx++;
            din_beats++;
            if (m_axis_din_tlast) n_last++;
         end
         if (m_axis_ctrl_tvalid && m_axis_ctrl_tready) begin
            if (exp_ctrl_q.size() == 0) begin
               chk("ctrl_unexpected", m_axis_ctrl_tvalid, 0);
            end else begin
               logic [31:0] ec;
               ec = exp_ctrl_q.pop_front();
               chk("ctrl_data", m_axis_ctrl_tdata, ec);
            end
            hs_cyc = cyc;
            n_ctrl++;
         end
         d_stall     = m_axis_din_tvalid && !m_axis_din_tready;
         d_prev      = m_axis_din_tdata;
         d_prev_last = m_axis_din_tlast;
         c_stall     = m_axis_ctrl_tvalid && !m_axis_ctrl_tready;
         c_prev      = m_axis_ctrl_tdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(int len, int mx, logic [31:0] cw, int nblk);
      cur_len   = len;
      out_idx   = 0;
      din_beats = 0;
      n_last    = 0;
      n_ctrl    = 0;
      for (int i = 0; i < nblk; i++) exp_ctrl_q.push_back(cw);
      block_beats = LEN_W'(len);
      max_blocks  = mx;
      ctrl_word   = cw;
      en          = 1'b1;
   endtask

   task automatic wait_done(int bound);
      for (int i = 0; i < bound && !done; i++) @(negedge clk);
      chk("done_reached", done, 1);
   endtask

   task automatic wait_idle(int bound);
      for (int i = 0; i < bound && busy; i++) @(negedge clk);
      chk("busy_cleared", busy, 0);
   endtask

   task automatic wait_beats(int n, int bound);
      for (int i = 0; i < bound && din_beats < n; i++) @(negedge clk);
      chk("beats_reached", (din_beats >= n), 1);
   endtask

   task automatic stop_run();
      tick();
      en = 1'b0;
      wait_idle(50);
      chk("queue_din_empty", exp_din_q.size(), 0);
      chk("queue_ctrl_empty", exp_ctrl_q.size(), 0);
   endtask

   initial begin
      int viol;
      int nvalid;
      // ---- reset values
      repeat (3) tick();
      @(negedge clk);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_din_valid", m_axis_din_tvalid, 0);
      chk("rst_din_last", m_axis_din_tlast, 0);
      chk("rst_din_data", m_axis_din_tdata, 0);
      chk("rst_ctrl_valid", m_axis_ctrl_tvalid, 0);
      chk("rst_ctrl_data", m_axis_ctrl_tdata, 0);
      chk("rst_blocks", blocks_sent, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      reset = 1'b0;

      // ---- 4-beat blocks, budget 3, all ready
      start_run(4, 3, $urandom, 3);
      @(negedge clk);
      chk("ctrl_valid_before_en", m_axis_ctrl_tvalid, 0);
      @(negedge clk);
      chk("ctrl_valid_after_en", m_axis_ctrl_tvalid, 1);
      wait_done(200);
      chk("s1_blocks", blocks_sent, 3);
      chk("s1_beats", din_beats, 12);
      chk("s1_tlasts", n_last, 3);
      chk("s1_ctrls", n_ctrl, 3);
      stop_run();
      $display("scenario 1 done: beats=%0d blocks=%0d", din_beats, blocks_sent);

      // ---- 5-beat blocks, random source valid and sink ready
      tick();
      rand_src = 1;
      rand_rdy = 1;
      start_run(5, 4, $urandom, 4);
      wait_done(3000);
      chk("s2_blocks", blocks_sent, 4);
      chk("s2_beats", din_beats, 20);
      chk("s2_tlasts", n_last, 4);
      rand_src = 0;
      rand_rdy = 0;
      stop_run();
      $display("scenario 2 done: beats=%0d blocks=%0d", din_beats, blocks_sent);

      // ---- CTRL held off for 10 cycles
      tick();
      m_axis_ctrl_tready = 1'b0;
      start_run(3, 1, $urandom, 1);
      @(negedge clk);
      viol = 0;
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (s_axis_tready || m_axis_din_tvalid) viol++;
         if (m_axis_ctrl_tvalid) nvalid++;
      end
      chk("s3_no_data_while_ctrl_stalled", viol, 0);
      chk("s3_ctrl_valid_held", nvalid, 10);
      tick();
      m_axis_ctrl_tready = 1'b1;
      wait_done(100);
      chk("s3_din_after_ctrl_hs", first_din_cyc - hs_cyc, 2);
      chk("s3_beats", din_beats, 3);
      stop_run();
      $display("scenario 3 done: ctrl_hs=%0d first_din=%0d", hs_cyc, first_din_cyc);

      // ---- unlimited budget, en dropped after beat 3 of block 2
      tick();
      start_run(8, 0, $urandom, 2);
      wait_beats(11, 300);
      tick();
      en = 1'b0;
      wait_idle(200);
      chk("s4_blocks", blocks_sent, 2);
      chk("s4_beats", din_beats, 16);
      chk("s4_tlasts", n_last, 2);
      chk("s4_busy", busy, 0);
      chk("s4_ctrls", n_ctrl, 2);
      $display("scenario 4 done: beats=%0d blocks=%0d", din_beats, blocks_sent);

      // ---- reset after beat 2 of a 6-beat block
      tick();
      start_run(6, 0, $urandom, 1);
      wait_beats(2, 100);
      tick();
      reset = 1'b1;
      en = 1'b0;
      tick();
      reset = 1'b0;
      exp_din_q.delete();
      exp_ctrl_q.delete();
      @(negedge clk);
      chk("s5_din_valid", m_axis_din_tvalid, 0);
      chk("s5_ctrl_valid", m_axis_ctrl_tvalid, 0);
      chk("s5_blocks", blocks_sent, 0);
      chk("s5_s_tready", s_axis_tready, 0);
      tick();
      start_run(6, 2, $urandom, 2);
      @(negedge clk);
      @(negedge clk);
      chk("s5_restart_ctrl", m_axis_ctrl_tvalid, 1);
      wait_done(200);
      chk("s5_blocks_after", blocks_sent, 2);
      chk("s5_beats_after", din_beats, 12);
      stop_run();
      $display("scenario 5 done: beats=%0d blocks=%0d", din_beats, blocks_sent);

      // ---- ctrl_word changed mid-block
      tick();
      start_run(4, 2, 32'h11, 1);
      exp_ctrl_q.push_back(32'h22);
      wait_beats(2, 100);
      tick();
      ctrl_word = 32'h22;
      wait_done(200);
      chk("s6_ctrls", n_ctrl, 2);
      chk("s6_blocks", blocks_sent, 2);
      stop_run();
      $display("scenario 6 done: ctrls=%0d blocks=%0d", n_ctrl, blocks_sent);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ldpc_din_framer.md
# ldpc_din_framer

Framing stage between the Gaussian LLR generator and the LDPC decoder's DIN/CTRL inputs. It cuts the continuous 128-bit LLR stream into codeword-sized blocks, asserts `tlast` on each block's final beat, and issues one CTRL word ahead of every block. It also enforces an optional block budget and counts the blocks it has sent. This replaces the tied-off DIN `tlast` and the free-running CTRL valid in the BER tester datapath.

## Interface
Parameters:
- `DATA_W`, 128: DIN/LLR stream width.
- `LEN_W`, 16: width of the beats-per-block count.

Ports:
- `clk`  in  1  datapath clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable, level-sensitive.
- `block_beats`  in  LEN_W  beats per codeword; sampled at each block start; 0 is illegal (block not started).
- `max_blocks`  in  32  block budget per run; 0 means unlimited; sampled when a run starts.
- `ctrl_word`  in  32  decoder control word; sampled at each block start.
- `s_axis_tdata`  in  DATA_W  LLR beats from the generator.
- `s_axis_tvalid`  in  1  generator beat valid.
- `s_axis_tready`  out  1  backpressure to the generator.
- `m_axis_din_tdata`  out  DATA_W  framed LLR beats to the decoder.
- `m_axis_din_tvalid`  out  1  DIN beat valid.
- `m_axis_din_tready`  in  1  decoder DIN ready.
- `m_axis_din_tlast`  out  1  high on the last beat of each block.
- `m_axis_ctrl_tdata`  out  32  latched `ctrl_word`.
- `m_axis_ctrl_tvalid`  out  1  CTRL word valid.
- `m_axis_ctrl_tready`  in  1  decoder CTRL ready.
- `blocks_sent`  out  64  number of blocks fully delivered in the current run.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  high in the DONE state.

## Operation
- States: IDLE, CTRL, DATA, DONE.
- IDLE → CTRL when `en`=1 and `block_beats`≠0.
  - On this transition: latch `block_beats`, `ctrl_word` and `max_blocks`; clear `blocks_sent`.
- CTRL:
  - `m_axis_ctrl_tvalid`=1 and `m_axis_ctrl_tdata` are held stable until `m_axis_ctrl_tready`.
  - The cycle after the handshake: state DATA, input beat counter `in_cnt`=0.
- DATA:
  - The output is a single register stage.
  - `s_axis_tready` = (state==DATA) && (`in_cnt` < len) && (!`m_axis_din_tvalid` || `m_axis_din_tready`).
  - On each accepted beat, the output register loads the data with `tlast` = (`in_cnt`==len-1), and `in_cnt` increments.
  - Once `in_cnt`==len, no further beats are accepted. The block's beats never mix with the next block's.
- Block completion, when the output handshake fires with `tlast`=1:
  - `blocks_sent` increments by 1.
  - If `max_blocks`≠0 and the new count equals `max_blocks` → DONE.
  - Else if `en`=1 → CTRL, re-latching `block_beats` and `ctrl_word`; if `block_beats`=0 at that point → IDLE instead.
  - Else → IDLE.
- `en` deasserted mid-block: the current block completes in full; no truncation and no partial `tlast`. Then IDLE.
- DONE: outputs idle; `blocks_sent` holds. Leaves to IDLE when `en`=0.
- Changes to `block_beats` or `ctrl_word` mid-block have no effect until the next block start.
- `blocks_sent` is 64-bit and wraps modulo 2^64. A budget compare is never reached beyond 2^32 blocks.

## Timing
- Reset values:
  - state IDLE, `in_cnt`=0.
  - `s_axis_tready`=0.
  - `m_axis_din_tvalid`=0, `m_axis_din_tlast`=0, `m_axis_din_tdata`=0.
  - `m_axis_ctrl_tvalid`=0, `m_axis_ctrl_tdata`=0.
  - `blocks_sent`=0, `busy`=0, `done`=0.
- `en` rising → `m_axis_ctrl_tvalid` high on the next cycle.
- CTRL handshake at cycle t → `s_axis_tready` may assert at t+1.
- Input-to-output latency: 1 cycle.
- Throughput: 1 beat/cycle with `m_axis_din_tready` held high.
- Per-block overhead: `tlast` handshake at t → CTRL valid at t+1 → earliest next DATA acceptance at t+2 (with `m_axis_ctrl_tready`=1).
- AXI-S rules on both masters: once valid is asserted, it and its data stay stable until ready.
- `s_axis_tready` has a combinational path from `m_axis_din_tready`. No combinational path exists from any input to any valid.
- `reset` mid-block: all outputs return to their reset values on the next edge, and the partial block is discarded.

## Test plan
- `block_beats`=4, `max_blocks`=3, `en`=1, all readies high, generator always valid:
  - expect 3 CTRL handshakes and 12 DIN beats;
  - `tlast` on beats 4, 8, 12;
  - `blocks_sent`=3, then `done`=1;
  - DIN data equals input order.
- `block_beats`=5, random `m_axis_din_tready` at 50% and random `s_axis_tvalid`:
  - no beat lost or duplicated;
  - tdata/tlast stable while stalled;
  - `tlast` only every 5th output beat.
- `m_axis_ctrl_tready` held low for 10 cycles:
  - `s_axis_tready` stays 0 and no DIN beat is emitted;
  - the first DIN beat follows the CTRL handshake by 2 cycles.
- `block_beats`=8, `max_blocks`=0; drop `en` after beat 3 of block 2:
  - block 2 completes all 8 beats with `tlast`, then IDLE;
  - `blocks_sent`=2, `busy`=0.
- Assert `reset` after beat 2 of a 6-beat block:
  - next cycle, all valids are 0 and `blocks_sent`=0;
  - a new run starts cleanly with a CTRL word.
- Change `ctrl_word` from 0x11 to 0x22 mid-block:
  - the current block's CTRL was 0x11;
  - the next block's CTRL is 0x22.
